// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive sequencer.
package uart_rx_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  // Bit-timer counter width: clog2 of the bit period, never below 1.
  function automatic int cnt_width(input int clks);
    return (clks <= 2) ? 1 : $clog2(clks);
  endfunction

endpackage

// File: rtl/uart_rx_sequencer_if.sv
// Serial line, consumer handshake and status bundle of the receive sequencer.
// master: the sequencer itself; slave: the pad/consumer side.
interface uart_rx_sequencer_if;

  logic rx;
  logic data_read;
  logic err_clear;
  logic rx_out;
  logic shift_strobe;
  logic packet_done;
  logic rx_busy;
  logic data_ready;
  logic framing_error;
  logic overrun_error;

  modport master (
    input  rx, data_read, err_clear,
    output rx_out, shift_strobe, packet_done, rx_busy,
           data_ready, framing_error, overrun_error
  );

  modport slave (
    output rx, data_read, err_clear,
    input  rx_out, shift_strobe, packet_done, rx_busy,
           data_ready, framing_error, overrun_error
  );

endinterface

// File: rtl/uart_rx_sequencer_bit_timer.sv
// Bit-period down-counter. Sample event whenever the count is zero; the
// event reloads a full bit period, and an explicit load overrides both.
// The event output is named evt because "event" is a reserved word.
import uart_rx_pkg::*;

module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int W            = cnt_width(CLKS_PER_BIT)
) (
  input  logic         clk,
  input  logic         n_Rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         evt
);

  localparam logic [W-1:0] RELOAD = W'(CLKS_PER_BIT - 1);

  assign evt = (cnt == '0);

  // Load wins; otherwise reload on the event, else count down.
  always_ff @(posedge clk or negedge n_Rst) begin
    if (!n_Rst)    cnt <= '0;
    else if (load) cnt <= load_val;
    else if (evt)  cnt <= RELOAD;
    else           cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: start-bit detection, mid-bit sampling, shift and
// latch strobes for the external 8-bit buffer, data-ready and sticky
// framing/overrun status.
// Optional macro UART_RX_SYNC_EN: put rx through a 2-flop synchronizer
// (reset to 1) before it is used; adds 2 cycles of latency.
import uart_rx_pkg::*;

module uart_rx_sequencer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 n_Rst,
  uart_rx_sequencer_if.master  bus
);

  localparam int              CW   = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0]   HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]      LAST = 3'(DATA_BITS - 1);

  logic          rx_s;
  rx_state_e     state, state_nxt;
  logic [2:0]    bit_idx, idx_nxt;
  logic          load, evt;
  logic [CW-1:0] bit_cnt;
  logic          strobe, done, fe_set;
  logic          dr_q, ovr_q, fe_q;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchronizer; idle-high reset so no false start bit.
  always_ff @(posedge clk or negedge n_Rst) begin
    if (!n_Rst) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], bus.rx};
  end

  assign rx_s = sync_q[1];
`else
  assign rx_s = bus.rx;
`endif

  assign bus.rx_out = rx_s;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT), .W(CW)) u_timer (
    .clk      (clk),
    .n_Rst    (n_Rst),
    .load     (load),
    .load_val (HALF),
    .cnt      (bit_cnt),
    .evt      (evt)
  );

  // Timer event and zero count must agree at all times.
  always @(posedge clk) begin
    if (n_Rst) assert (evt == (bit_cnt == '0));
  end

  // FSM state and bit index registers.
  always_ff @(posedge clk or negedge n_Rst) begin
    if (!n_Rst) begin
      state   <= IDLE;
      bit_idx <= '0;
    end else begin
      state   <= state_nxt;
      bit_idx <= idx_nxt;
    end
  end

  // Next state plus the combinational strobes, so the buffer captures the
  // very rx_out value the sequencer samples on the same edge.
  always_comb begin
    state_nxt = state;
    idx_nxt   = bit_idx;
    load      = 1'b0;
    strobe    = 1'b0;
    done      = 1'b0;
    fe_set    = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          load      = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (evt) begin
          if (!rx_s) begin
            state_nxt = DATA;
            idx_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (evt) begin
          strobe  = 1'b1;
          idx_nxt = bit_idx + 3'd1;
          if (bit_idx == LAST) state_nxt = STOP;
        end
      end
      STOP: begin
        if (evt) begin
          if (rx_s) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else begin
            fe_set    = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Status: data_ready set by a completed byte (wins over a same-cycle read);
  // sticky errors hold until err_clear, and a same-cycle set wins.
  always_ff @(posedge clk or negedge n_Rst) begin
    if (!n_Rst) begin
      dr_q  <= 1'b0;
      ovr_q <= 1'b0;
      fe_q  <= 1'b0;
    end else begin
      if (done)               dr_q <= 1'b1;
      else if (bus.data_read) dr_q <= 1'b0;
      ovr_q <= (done & dr_q & ~bus.data_read) | (ovr_q & ~bus.err_clear);
      fe_q  <= fe_set | (fe_q & ~bus.err_clear);
    end
  end

  assign bus.shift_strobe  = strobe;
  assign bus.packet_done   = done;
  assign bus.rx_busy       = (state != IDLE);
  assign bus.data_ready    = dr_q;
  assign bus.framing_error = fe_q;
  assign bus.overrun_error = ovr_q;

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Scoreboard bench for uart_rx_sequencer: the driver serialises bytes and
// queues the expected strobe/latch cycles; a negedge monitor assembles the
// buffer and checks each pulse against the queues. Status flags are checked
// against a frame-level model.
module tb_uart_rx_sequencer;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk   = 1'b0;
  logic n_Rst = 1'b0;
  always #5 clk = ~clk;

  uart_rx_sequencer_if bus();

  uart_rx_sequencer #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .n_Rst (n_Rst),
    .bus   (bus.master)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic bitv; } strobe_t;
  typedef struct { int cyc; logic [7:0] data; } done_t;
  strobe_t sq[$];
  done_t   dq[$];

  int checks = 0;
  int errors = 0;
  logic m_dr = 1'b0, m_ovr = 1'b0, m_fe = 1'b0;
  logic [7:0] shreg = '0, udata = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: model the external buffer and match pulses to the queues.
  always @(negedge clk) begin
    if (n_Rst) begin
      if (bus.shift_strobe) begin
        chk("strobe_expected", 32'(sq.size() != 0), 1);
        if (sq.size() != 0) begin
          strobe_t s;
          s = sq.pop_front();
          chk("strobe_cycle", cyc, s.cyc);
          chk("strobe_bit", bus.rx_out, s.bitv);
        end
        shreg = {bus.rx_out, shreg[7:1]};
      end
      if (bus.packet_done) begin
        udata = shreg;
        chk("done_expected", 32'(dq.size() != 0), 1);
        if (dq.size() != 0) begin
          done_t d;
          d = dq.pop_front();
          chk("done_cycle", cyc, d.cyc);
          chk("udata_in", udata, d.data);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_data_ready"}, bus.data_ready, m_dr);
    chk({tag, "_overrun"}, bus.overrun_error, m_ovr);
    chk({tag, "_framing"}, bus.framing_error, m_fe);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_strobe"}, bus.shift_strobe, 0);
    chk({tag, "_done"}, bus.packet_done, 0);
    chk({tag, "_busy"}, bus.rx_busy, 0);
    chk({tag, "_rx_out"}, bus.rx_out, 1);
    check_flags(tag);
  endtask

  task automatic push_strobe(input int t, input logic v);
    strobe_t s;
    s.cyc  = t;
    s.bitv = v;
    sq.push_back(s);
  endtask

  // Send one frame starting at the next cycle. Optional data_read/err_clear
  // pulses land exactly on the stop sample cycle.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                            input bit rd_at_done, input bit clr_at_done,
                            input int tail);
    int t0;
    logic [9:0] bits;
    logic set_ovr;
    done_t d;
    bits = {stop_ok, b, 1'b0};
    @(posedge clk);
    #1;
    t0 = cyc;
    for (int k = 0; k < 8; k++) push_strobe(t0 + HALF + (k + 1) * CPB + LAT, b[k]);
    if (stop_ok) begin
      d.cyc  = t0 + HALF + 9 * CPB + LAT;
      d.data = b;
      dq.push_back(d);
    end
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < CPB; j++) begin
        bus.rx        = bits[i];
        bus.data_read = (i == 9 && j == HALF + LAT && rd_at_done);
        bus.err_clear = (i == 9 && j == HALF + LAT && clr_at_done);
        tick(1);
      end
    end
    bus.data_read = 1'b0;
    bus.err_clear = 1'b0;
    set_ovr = 1'b0;
    if (stop_ok) begin
      set_ovr = m_dr && !rd_at_done;
      m_dr    = 1'b1;
    end else if (rd_at_done) begin
      m_dr = 1'b0;
    end
    m_ovr = (m_ovr && !clr_at_done) || set_ovr;
    m_fe  = (m_fe && !clr_at_done) || !stop_ok;
    if (!stop_ok) begin
      tick(tail);
      chk("busy_in_break", bus.rx_busy, 1);
      bus.rx = 1'b1;
      tick(3 + LAT);
      chk("idle_after_break", bus.rx_busy, 0);
    end
    check_flags("frame");
  endtask

  task automatic pulse_read();
    bus.data_read = 1'b1;
    tick(1);
    bus.data_read = 1'b0;
    tick(1);
    m_dr = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.err_clear = 1'b1;
    tick(1);
    bus.err_clear = 1'b0;
    tick(1);
    m_fe  = 1'b0;
    m_ovr = 1'b0;
  endtask

  initial begin
    int t0;
    logic [7:0] rb;
    bus.rx        = 1'b1;
    bus.data_read = 1'b0;
    bus.err_clear = 1'b0;
    tick(3);
    check_reset("reset");
    n_Rst = 1'b1;
    tick(2);

    // Clean frame with known timing.
    send_frame(8'hA5, 1, 0, 0, 0);
    pulse_read();
    check_flags("after_read");

    // Start-bit glitch: 5 low cycles, rejected at the start sample.
    @(posedge clk);
    #1;
    t0 = cyc;
    bus.rx = 1'b0;
    tick(5);
    bus.rx = 1'b1;
    tick(8 + LAT - 5);
    chk("glitch_busy_at_sample", bus.rx_busy, 1);
    tick(1);
    chk("glitch_idle_after", bus.rx_busy, 0);
    tick(4);

    // Stop bit held low.
    send_frame(8'h3C, 0, 0, 0, 20);
    pulse_clear();
    check_flags("fe_cleared");

    // Overrun on back-to-back frames without a read.
    send_frame(8'h11, 1, 0, 0, 0);
    send_frame(8'h22, 1, 0, 0, 0);
    pulse_clear();
    check_flags("ovr_cleared");
    pulse_read();

    // Read coincident with the second packet_done.
    send_frame(8'h33, 1, 0, 0, 0);
    send_frame(8'h44, 1, 1, 0, 0);
    pulse_read();

    // err_clear on the cycle a framing error is set: the set wins.
    send_frame(8'h96, 0, 0, 1, 5);
    pulse_clear();

    // Reset 60 cycles into a frame, then a clean frame.
    send_frame(8'h01, 1, 0, 0, 0);
    rb = 8'hC3;
    @(posedge clk);
    #1;
    t0 = cyc;
    for (int k = 0; k < 8; k++)
      if (HALF + (k + 1) * CPB + LAT < 60) push_strobe(t0 + HALF + (k + 1) * CPB + LAT, rb[k]);
    for (int c = 0; c < 60; c++) begin
      bus.rx = (c < CPB) ? 1'b0 : rb[(c / CPB) - 1];
      tick(1);
    end
    n_Rst  = 1'b0;
    bus.rx = 1'b1;
    #1;
    m_dr = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
    check_reset("mid_reset");
    tick(3);
    n_Rst = 1'b1;
    tick(2);
    send_frame(8'h5A, 1, 0, 0, 0);

    // Randomised frames and handshakes.
    for (int n = 0; n < 20; n++) begin
      send_frame(8'($urandom), $urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(1, 20));
      case ($urandom_range(0, 3))
        0: pulse_read();
        1: pulse_clear();
        default: tick($urandom_range(0, 5));
      endcase
    end

    tick(5);
    chk("strobe_queue_drained", sq.size(), 0);
    chk("done_queue_drained", dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_sequencer.md
# uart_rx_sequencer

Receive-side sequencer for the UART debugger. It watches the serial line and detects start bits. It generates the one-cycle `shift_strobe` and `packet_done` pulses that drive the 8-bit receive shift/holding buffer. It also tracks data-ready, framing and overrun status for the debugger control logic. It sits between the pad-side `rx` line and the receive buffer, and it is the only block that sequences that buffer.

## Interface
- `CLKS_PER_BIT`, default 16: clk cycles per serial bit; legal range 4..65535.
- `clk`  in  1  system clock.
- `n_Rst`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial line; idles high.
- `data_read`  in  1  one-cycle pulse from the consumer acknowledging `UDATA_IN`.
- `err_clear`  in  1  one-cycle pulse; clears sticky errors.
- `rx_out`  out  1  line value the sequencer samples; wired to the buffer's `rx`.
- `shift_strobe`  out  1  shift one data bit into the buffer.
- `packet_done`  out  1  latch the assembled byte into `UDATA_IN`.
- `rx_busy`  out  1  frame in progress.
- `data_ready`  out  1  unread byte is held in `UDATA_IN`.
- `framing_error`  out  1  sticky; stop bit sampled low.
- `overrun_error`  out  1  sticky; new byte arrived while `data_ready` was still set.

## Operation
- One clock, `clk`. Reset is asynchronous and active-low on `n_Rst`.
- Frame format is fixed: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- Bit timer:
  - Down-counter `cnt`, width clog2(`CLKS_PER_BIT`).
  - A sample event occurs in any cycle with `cnt`==0.
  - On each event, `cnt` reloads `CLKS_PER_BIT`-1.
- Bit index: 3-bit counter, 0..7.
- FSM states:
  - IDLE: if `rx_out`==0, load `cnt`=`CLKS_PER_BIT`/2-1 (integer division) and go to START.
  - START: on event, if `rx_out`==0 go to DATA with bit index 0; otherwise the low level was a glitch, so go to IDLE.
  - DATA: on event, assert `shift_strobe` and increment the bit index. The event at bit index 7 goes to STOP.
  - STOP: on event, if `rx_out`==1 assert `packet_done` and go to IDLE. Otherwise set `framing_error`, suppress `packet_done`, and go to BREAK.
  - BREAK: wait for `rx_out`==1, then go to IDLE.
- `rx_busy` = (state != IDLE).
- `data_ready`:
  - Set by `packet_done`; cleared by `data_read`.
  - `packet_done` and `data_read` in the same cycle: `data_ready` stays 1 and no overrun is flagged.
- `overrun_error` is set when `packet_done` occurs with `data_ready`==1 and `data_read`==0. The byte is still latched into the buffer, overwriting the old one.
- Sticky errors:
  - Cleared only by `err_clear` or reset.
  - If a set and `err_clear` coincide, the set wins.
- `data_read` while `data_ready`==0 is ignored.

## Timing
- All state, counters and status flags are registered.
- `shift_strobe` and `packet_done` are combinational decodes of state, event and `rx_out`. This lets the buffer capture the same `rx_out` value on the same edge.
- Cycle numbers below are relative to cycle 0, the first cycle `rx_out`==0 is seen in IDLE:
  - Start sample at cycle `CLKS_PER_BIT`/2.
  - Data bit k at `CLKS_PER_BIT`/2 + (k+1)·`CLKS_PER_BIT`.
  - Stop bit at `CLKS_PER_BIT`/2 + 9·`CLKS_PER_BIT`.
- `data_ready`, `overrun_error` and `framing_error` change on the edge ending the event cycle.
- A new start bit is detectable from the cycle after the stop event, so back-to-back frames work.
- Reset values: `shift_strobe`, `packet_done`, `rx_busy`, `data_ready`, `framing_error` and `overrun_error` are all 0; `rx_out` is 1; state is IDLE; counters are 0.
- Reset mid-frame aborts the frame with no pulses.

## Configuration
- `UART_RX_SYNC_EN` defined:
  - `rx` passes through a 2-flop synchronizer, both flops reset to 1, before it becomes `rx_out`.
  - Adds 2 cycles of latency from `rx` to all events.
- `UART_RX_SYNC_EN` undefined: `rx_out` = `rx` directly, for use when `rx` is already synchronous.

## Structure
- Package `uart_rx_pkg`:
  - FSM state enum: IDLE, START, DATA, STOP, BREAK.
  - `DATA_BITS`=8.
  - A clog2-based counter-width function.
- Sub-module `uart_bit_timer`:
  - Inputs: load, load value.
  - Outputs: down-counter and `event`.
  - Instantiated once.
- Synchronizer and FSM stay in the top module.

## Test plan
- `CLKS_PER_BIT`=16, frame 0xA5 (no sync):
  - `shift_strobe` pulses at cycles 24, 40, …, 136.
  - `packet_done` pulses at cycle 152.
  - Buffer `UDATA_IN`=0xA5; `data_ready`=1.
- `rx` low for 5 cycles then high:
  - FSM returns to IDLE at cycle 8.
  - No strobes; `rx_busy` is 0 from cycle 9.
- Frame 0x3C with stop bit held low:
  - `framing_error`=1 and no `packet_done`.
  - `rx_busy` stays 1 until `rx` returns high.
- Two frames 0x11 then 0x22, no `data_read`:
  - `overrun_error`=1 after the second stop bit.
  - `UDATA_IN`=0x22.
  - `err_clear` clears `overrun_error`.
- `data_read` coincident with the `packet_done` of the second frame: `data_ready` stays 1 and `overrun_error` stays 0.
- `n_Rst` asserted at cycle 60 of a frame:
  - All outputs go to reset values immediately.
  - A following clean frame 0x5A is received correctly.
  - With `UART_RX_SYNC_EN` defined, all event cycles shift by +2.
